// File: rtl/i2s_slot_sched.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// i2s_slot_sched
//   Slot scheduler between two sample sources and the I2S transmitter.
//   Each source is buffered in a DEPTH-entry FIFO. A routing mode is latched
//   on every left-slot request and held for the whole frame. For each slot
//   request the scheduler pops the required FIFO(s) and registers the 16-bit
//   word for the transmitter.
//
// Ports
//   i_clk, i_rst_n        system clock, asynchronous active-low reset
//   i_mode[1:0]           requested mode: 00 mute, 01 mono src0,
//                         10 stereo (src0 L / src1 R), 11 mix
//   i_s0_valid/i_s0_data  source 0 push, o_s0_ready = FIFO 0 not full
//   i_s1_valid/i_s1_data  source 1 push, o_s1_ready = FIFO 1 not full
//   i_slot_req            one-cycle request for the next slot word
//   i_slot_right          qualifies i_slot_req: 0 left (frame start), 1 right
//   o_sample[15:0]        signed word for the requested slot (registered)
//   o_mode[1:0]           mode in force for the current frame
//   o_underrun            one-cycle pulse when a required FIFO was empty
//   o_underrun_cnt[7:0]   saturating underrun event count
// ---------------------------------------------------------------------------
module i2s_slot_sched #(
  parameter int DEPTH = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [1:0]         i_mode,
  input  logic               i_s0_valid,
  input  logic signed [15:0] i_s0_data,
  output logic               o_s0_ready,
  input  logic               i_s1_valid,
  input  logic signed [15:0] i_s1_data,
  output logic               o_s1_ready,
  input  logic               i_slot_req,
  input  logic               i_slot_right,
  output logic signed [15:0] o_sample,
  output logic [1:0]         o_mode,
  output logic               o_underrun,
  output logic [7:0]         o_underrun_cnt
);

  localparam int DATA_W = 16;
  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW     = AW + 1;

  typedef enum logic [1:0] {
    MODE_MUTE   = 2'b00,
    MODE_MONO   = 2'b01,
    MODE_STEREO = 2'b10,
    MODE_MIX    = 2'b11
  } mode_e;

  // Average of two signed words: 17-bit sum, arithmetic shift right by one,
  // low 16 bits kept. The result always fits, so no saturation is needed.
  function automatic logic signed [DATA_W-1:0] mix_avg(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    logic [DATA_W:0] sum;
    sum = {a[DATA_W-1], a} + {b[DATA_W-1], b};
    return sum[DATA_W:1];
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // FIFO storage (data only, not reset) and control state
  logic signed [DATA_W-1:0] mem0 [DEPTH];
  logic signed [DATA_W-1:0] mem1 [DEPTH];
  logic [AW-1:0] wptr0, rptr0, wptr1, rptr1;
  logic [CW-1:0] cnt0, cnt1;

  logic empty0, empty1;
  logic push0_p0, push1_p0;
  logic pop0_p0, pop1_p0;
  logic need0_p0, need1_p0;
  logic left_req_p0;
  logic [1:0] mode_p0;
  logic underrun_p0;
  logic signed [DATA_W-1:0] sample_nxt_p0;

  assign empty0     = (cnt0 == '0);
  assign empty1     = (cnt1 == '0);
  assign o_s0_ready = (cnt0 != CW'(DEPTH));
  assign o_s1_ready = (cnt1 != CW'(DEPTH));
  assign push0_p0   = i_s0_valid && o_s0_ready;
  assign push1_p0   = i_s1_valid && o_s1_ready;

  // ---- stage p0: request decode, FIFO pop decision, next sample ----
  always_comb begin
    left_req_p0   = i_slot_req && !i_slot_right;
    // A left request uses the newly requested mode; a right request the latched one.
    mode_p0       = left_req_p0 ? i_mode : o_mode;
    need0_p0      = 1'b0;
    need1_p0      = 1'b0;
    case (mode_p0)
      MODE_MUTE:   ;
      MODE_MONO:   need0_p0 = left_req_p0;
      MODE_STEREO: begin
        need0_p0 = left_req_p0;
        need1_p0 = i_slot_req && i_slot_right;
      end
      MODE_MIX: begin
        need0_p0 = left_req_p0;
        need1_p0 = left_req_p0;
      end
      default: ;
    endcase
    // Any missing source cancels every pop so the mix channels stay aligned.
    underrun_p0   = (need0_p0 && empty0) || (need1_p0 && empty1);
    pop0_p0       = need0_p0 && !underrun_p0;
    pop1_p0       = need1_p0 && !underrun_p0;
    // Default holds the word: covers underruns and mono/mix right repeats.
    sample_nxt_p0 = o_sample;
    if (i_slot_req) begin
      if (mode_p0 == MODE_MUTE)    sample_nxt_p0 = '0;
      else if (pop0_p0 && pop1_p0) sample_nxt_p0 = mix_avg(mem0[rptr0], mem1[rptr1]);
      else if (pop0_p0)            sample_nxt_p0 = mem0[rptr0];
      else if (pop1_p0)            sample_nxt_p0 = mem1[rptr1];
    end
  end

  // ---- stage p1: registered FIFO data writes ----
  always_ff @(posedge i_clk) begin
    if (push0_p0) mem0[wptr0] <= i_s0_data;
    if (push1_p0) mem1[wptr1] <= i_s1_data;
  end

  // ---- stage p1: registered control and outputs ----
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wptr0          <= '0;
      rptr0          <= '0;
      cnt0           <= '0;
      wptr1          <= '0;
      rptr1          <= '0;
      cnt1           <= '0;
      o_sample       <= '0;
      o_mode         <= MODE_MUTE;
      o_underrun     <= 1'b0;
      o_underrun_cnt <= '0;
    end else begin
      if (push0_p0) wptr0 <= wptr0 + AW'(1);
      if (pop0_p0)  rptr0 <= rptr0 + AW'(1);
      cnt0 <= cnt0 + CW'(push0_p0) - CW'(pop0_p0);
      if (push1_p0) wptr1 <= wptr1 + AW'(1);
      if (pop1_p0)  rptr1 <= rptr1 + AW'(1);
      cnt1 <= cnt1 + CW'(push1_p0) - CW'(pop1_p0);
      if (left_req_p0) o_mode <= i_mode;
      o_sample   <= sample_nxt_p0;
      o_underrun <= underrun_p0;
      if (underrun_p0) o_underrun_cnt <= sat_inc8(o_underrun_cnt);
    end
  end

endmodule

// File: tb/tb_i2s_slot_sched.sv
`timescale 1ns/1ps
module tb_i2s_slot_sched;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [1:0]         mode = 2'b00;
  logic               s0_valid = 1'b0;
  logic signed [15:0] s0_data = '0;
  logic               s0_ready;
  logic               s1_valid = 1'b0;
  logic signed [15:0] s1_data = '0;
  logic               s1_ready;
  logic               slot_req = 1'b0;
  logic               slot_right = 1'b0;
  logic signed [15:0] sample;
  logic [1:0]         mode_o;
  logic               underrun;
  logic [7:0]         ur_cnt;

  int n_checks = 0;
  int n_errors = 0;

  i2s_slot_sched #(.DEPTH(4)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_mode         (mode),
    .i_s0_valid     (s0_valid),
    .i_s0_data      (s0_data),
    .o_s0_ready     (s0_ready),
    .i_s1_valid     (s1_valid),
    .i_s1_data      (s1_data),
    .o_s1_ready     (s1_ready),
    .i_slot_req     (slot_req),
    .i_slot_right   (slot_right),
    .o_sample       (sample),
    .o_mode         (mode_o),
    .o_underrun     (underrun),
    .o_underrun_cnt (ur_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push0(input logic [15:0] d);
    s0_valid = 1'b1; s0_data = d;
    tick();
    s0_valid = 1'b0;
  endtask

  task automatic push_both(input logic [15:0] a, input logic [15:0] b);
    s0_valid = 1'b1; s0_data = a;
    s1_valid = 1'b1; s1_data = b;
    tick();
    s0_valid = 1'b0; s1_valid = 1'b0;
  endtask

  task automatic req(input logic right);
    slot_req = 1'b1; slot_right = right;
    tick();
    slot_req = 1'b0; slot_right = 1'b0;
  endtask

  // Request, check the word and underrun flag in the following cycle, then idle.
  task automatic req_chk(input string tag, input logic right,
                         input logic [15:0] exp_sample, input logic exp_ur);
    req(right);
    check({tag, "_sample"}, sample, exp_sample);
    check({tag, "_ur"}, {15'd0, underrun}, {15'd0, exp_ur});
    tick();
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    check("rst_sample", sample, 16'h0000);
    check("rst_mode", {14'd0, mode_o}, 16'd0);
    check("rst_ur", {15'd0, underrun}, 16'd0);
    check("rst_cnt", {8'd0, ur_cnt}, 16'd0);
    check("rst_rdy0", {15'd0, s0_ready}, 16'd1);
    check("rst_rdy1", {15'd0, s1_ready}, 16'd1);
    rst_n = 1'b1;
    tick();

    // Stereo: each slot pops its own source
    mode = 2'b10;
    push_both(16'h1000, 16'h2000);
    push_both(16'h1001, 16'h2001);
    req_chk("st_L0", 1'b0, 16'h1000, 1'b0);
    check("st_mode", {14'd0, mode_o}, 16'd2);
    req_chk("st_R0", 1'b1, 16'h2000, 1'b0);
    req_chk("st_L1", 1'b0, 16'h1001, 1'b0);
    req_chk("st_R1", 1'b1, 16'h2001, 1'b0);
    check("st_cnt", {8'd0, ur_cnt}, 16'd0);

    // Mix: (a+b)>>>1 at the boundaries, right repeats left
    mode = 2'b11;
    push_both(16'h7FFF, 16'h7FFF);
    req_chk("mix_pos_L", 1'b0, 16'h7FFF, 1'b0);
    req_chk("mix_pos_R", 1'b1, 16'h7FFF, 1'b0);
    push_both(16'h8000, 16'h8000);
    req_chk("mix_neg_L", 1'b0, 16'h8000, 1'b0);
    req_chk("mix_neg_R", 1'b1, 16'h8000, 1'b0);
    push_both(16'h0003, 16'hFFFE);
    req_chk("mix_rnd_L", 1'b0, 16'h0000, 1'b0);
    req_chk("mix_rnd_R", 1'b1, 16'h0000, 1'b0);

    // Mono with empty FIFO: three underruns, sample held
    mode = 2'b01;
    req(1'b0);
    check("ur1_sample", sample, 16'h0000);
    check("ur1_ur", {15'd0, underrun}, 16'd1);
    tick();
    check("ur1_pulse_end", {15'd0, underrun}, 16'd0);
    req_chk("ur2", 1'b0, 16'h0000, 1'b1);
    req_chk("ur3", 1'b0, 16'h0000, 1'b1);
    check("ur_cnt3", {8'd0, ur_cnt}, 16'd3);
    push0(16'h0042);
    req_chk("mono_L", 1'b0, 16'h0042, 1'b0);
    req_chk("mono_R", 1'b1, 16'h0042, 1'b0);
    check("mono_cnt", {8'd0, ur_cnt}, 16'd3);

    // Mute: fill src0, no pops across two frames, mid-frame mode change ignored
    mode = 2'b00;
    req_chk("mute_L0", 1'b0, 16'h0000, 1'b0);
    push0(16'h00A1);
    push0(16'h00A2);
    push0(16'h00A3);
    check("fill3_rdy", {15'd0, s0_ready}, 16'd1);
    push0(16'h00A4);
    check("fill4_rdy", {15'd0, s0_ready}, 16'd0);
    push0(16'h00FF);
    req_chk("mute_R0", 1'b1, 16'h0000, 1'b0);
    req_chk("mute_L1", 1'b0, 16'h0000, 1'b0);
    mode = 2'b01;
    req_chk("mid_R1", 1'b1, 16'h0000, 1'b0);
    check("mid_mode", {14'd0, mode_o}, 16'd0);
    check("mute_rdy", {15'd0, s0_ready}, 16'd0);
    req_chk("mono_first", 1'b0, 16'h00A1, 1'b0);
    check("mono_mode", {14'd0, mode_o}, 16'd1);
    check("pop_rdy", {15'd0, s0_ready}, 16'd1);
    req_chk("mono_A2", 1'b0, 16'h00A2, 1'b0);
    req_chk("mono_A3", 1'b0, 16'h00A3, 1'b0);

    // Mix with src1 empty: underrun, src0 keeps its single word
    mode = 2'b11;
    req_chk("mix_ur", 1'b0, 16'h00A3, 1'b1);
    check("mix_ur_cnt", {8'd0, ur_cnt}, 16'd4);
    s1_valid = 1'b1; s1_data = 16'h0010;
    tick();
    s1_valid = 1'b0;
    req_chk("mix_both", 1'b0, 16'h005A, 1'b0);
    mode = 2'b01;
    req_chk("src0_drained", 1'b0, 16'h005A, 1'b1);

    // Push and request on the same cycle with src0 empty
    s0_valid = 1'b1; s0_data = 16'h0077;
    req(1'b0);
    s0_valid = 1'b0;
    check("pp_sample", sample, 16'h005A);
    check("pp_ur", {15'd0, underrun}, 16'd1);
    tick();
    req_chk("pp_next", 1'b0, 16'h0077, 1'b0);
    check("pp_cnt", {8'd0, ur_cnt}, 16'd6);

    // Saturation of the underrun counter
    for (int i = 0; i < 299; i++) begin
      req(1'b0);
      tick();
    end
    req_chk("sat_last", 1'b0, 16'h0077, 1'b1);
    check("sat_cnt", {8'd0, ur_cnt}, 16'd255);

    // Asynchronous reset mid-frame discards buffered words
    push0(16'h0011);
    push0(16'h0022);
    push0(16'h0033);
    push0(16'h0044);
    req_chk("pre_rst", 1'b0, 16'h0011, 1'b0);
    push0(16'h0055);
    check("pre_rst_rdy", {15'd0, s0_ready}, 16'd0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_sample", sample, 16'h0000);
    check("arst_mode", {14'd0, mode_o}, 16'd0);
    check("arst_ur", {15'd0, underrun}, 16'd0);
    check("arst_cnt", {8'd0, ur_cnt}, 16'd0);
    check("arst_rdy0", {15'd0, s0_ready}, 16'd1);
    check("arst_rdy1", {15'd0, s1_ready}, 16'd1);
    rst_n = 1'b1;
    tick();
    mode = 2'b01;
    push0(16'h0066);
    req_chk("post_rst", 1'b0, 16'h0066, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
